ro_line_fill: RTL and testbench
===============================

RO_LINE_FILL -- requirements
Module: ro_line_fill

Interface
REQ-001 Parameter LW, default 512, line width in bits; SHALL be a multiple of 32.
REQ-002 Parameter TMO, default 255, maximum cycles waited for one memory ack before abort.
REQ-003 Derived BEATS = LW/32 (16 at default); LB = LW/8 bytes per line (64 at default).
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 m_start  input  1  fill request pulse from the cache miss handler.
REQ-007 m_addr  input  32  byte address of the missing line; low log2(LB) bits ignored.
REQ-008 m_data  output  LW  assembled line; word i in bits [32*i+31:32*i].
REQ-009 m_done  output  1  one-cycle pulse; fill complete, m_data valid.
REQ-010 m_err  output  1  one-cycle pulse coincident with m_done; fill aborted by timeout.
REQ-011 busy  output  1  high while a fill is in progress (states REQ and DONE).
REQ-012 mem_req  output  1  word read request to the memory bus.
REQ-013 mem_addr  output  32  word byte address; always 4-byte aligned.
REQ-014 mem_rdata  input  32  read data; sampled only when mem_ack = 1.
REQ-015 mem_ack  input  1  beat accept and data valid, single cycle per word.

Function
REQ-016 States: IDLE, REQ, DONE; encoding is implementer's choice.
REQ-017 IDLE: on m_start = 1, register base = m_addr with low log2(LB) bits cleared, beat = 0, wait counter = 0, clear error flag; next state REQ.
REQ-018 REQ: mem_req = 1, mem_addr = base + 4*beat, both driven from registers and stable until ack.
REQ-019 REQ with mem_ack = 1: write mem_rdata into m_data lane beat, clear wait counter; if beat = BEATS-1, go to DONE, else increment beat.
REQ-020 REQ with mem_ack = 0: increment wait counter; when it reaches TMO, set error flag, drop mem_req next cycle, go to DONE; lanes not yet filled keep their previous contents.
REQ-021 DONE: m_done = 1 for exactly one cycle, m_err = error flag, mem_req = 0; next state IDLE.
REQ-022 Minimum latency: m_start cycle to m_done cycle is BEATS+1 cycles with zero-wait acks (17 at default).
REQ-023 m_start in REQ or DONE SHALL be ignored, with no queuing; the requester waits for m_done before asserting it again.
REQ-024 m_start in the IDLE cycle directly after DONE SHALL be accepted (back-to-back fills).
REQ-025 mem_ack while mem_req = 0 SHALL be ignored; m_data is unchanged.
REQ-026 m_data holds its last value from m_done until it is overwritten, lane by lane, during the next fill.
REQ-027 Beat address arithmetic is 32-bit modulo; a line at 0xFFFFFFC0 fetches 0xFFFFFFC0..0xFFFFFFFC and never wraps into the next line.
REQ-028 The wait counter SHALL be wide enough to hold TMO and SHALL never wrap.

Reset
REQ-029 rst = 1 at a clock edge forces IDLE, beat = 0, wait counter = 0, error flag = 0, mem_req = 0, m_done = 0, m_err = 0, busy = 0, mem_addr = 0, m_data = 0.
REQ-030 Reset mid-fill SHALL abort the fill immediately, with no m_done pulse and mem_req low on the next cycle; a mem_ack arriving during or after reset is ignored.
REQ-031 m_start asserted together with rst SHALL be ignored.

Verification
REQ-032 Basic fill: m_start with m_addr = 0xABCDEF88 and mem_ack every cycle where mem_rdata = mem_addr -> mem_addr steps through 0xABCDEF80..0xABCDEFBC; m_data word i = 0xABCDEF80+4i; m_done pulses 17 cycles after m_start; m_err = 0.
REQ-033 Wait states: ack on every third REQ cycle -> mem_addr holds between acks; all 16 words correct; one m_done pulse.
REQ-034 Timeout: with TMO = 255, ack words 0..4, then withhold ack -> after 255 wait cycles m_done = 1 and m_err = 1 together; lanes 0..4 are new and lanes 5..15 are unchanged.
REQ-035 Ignored inputs: m_start pulsed during beat 7 and a stray mem_ack in IDLE -> the fill completes unaffected; no second fill; m_data is unchanged by the stray ack.
REQ-036 Reset mid-fill: assert rst during beat 9 -> next cycle mem_req = 0, busy = 0, m_data = 0; no m_done pulse; a fresh m_start at 0x00000000 then fills correctly.
REQ-037 Back-to-back and wrap: m_start at 0xFFFFFFC4 in the IDLE cycle right after a previous m_done -> accepted; addresses 0xFFFFFFC0..0xFFFFFFFC; no access outside that line.

Source files
------------

// File: rtl/ro_line_fill.sv
// Read-only cache line fill engine: fetches one LW-bit line as BEATS sequential
// 32-bit word reads, with a per-word ack timeout that aborts the fill.
module ro_line_fill #(
    parameter int LW  = 512,
    parameter int TMO = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m_start,
    input  logic [31:0]   m_addr,
    output logic [LW-1:0] m_data,
    output logic          m_done,
    output logic          m_err,
    output logic          busy,
    output logic          mem_req,
    output logic [31:0]   mem_addr,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack
);

    localparam int BEATS = LW / 32;
    localparam int LB    = LW / 8;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WW    = (TMO > 0) ? $clog2(TMO + 1) : 1;

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TMO - 1);
    localparam logic [31:0]   LINE_MASK = ~(32'(LB) - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [BW-1:0]   beat_r, beat_s;
    logic [WW-1:0]   wait_r, wait_s;
    logic            err_r, err_s;
    logic [31:0]     base_r, base_s;
    logic            mem_req_r, mem_req_s;
    logic [31:0]     mem_addr_r, mem_addr_s;
    logic            m_done_r, m_done_s;
    logic            m_err_r, m_err_s;
    logic            busy_r, busy_s;
    logic            lane_we_s;
    logic [LW-1:0]   m_data_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; the wait counter leaves REQ on reaching TMO, so it never wraps
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (m_start) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    if (beat_r == LAST_BEAT) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_REQ;
                    end
                end else begin
                    if (wait_r == WAIT_LAST) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_REQ;
                    end
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values for datapath and the registered outputs
    always_comb begin
        beat_s     = beat_r;
        wait_s     = wait_r;
        err_s      = err_r;
        base_s     = base_r;
        mem_req_s  = 1'b0;
        mem_addr_s = mem_addr_r;
        m_done_s   = 1'b0;
        m_err_s    = 1'b0;
        lane_we_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (m_start) begin
                    base_s     = m_addr & LINE_MASK;
                    beat_s     = {BW{1'b0}};
                    wait_s     = {WW{1'b0}};
                    err_s      = 1'b0;
                    mem_req_s  = 1'b1;
                    mem_addr_s = m_addr & LINE_MASK;
                end else begin
                    mem_req_s  = 1'b0;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    lane_we_s = 1'b1;
                    wait_s    = {WW{1'b0}};
                    if (beat_r == LAST_BEAT) begin
                        mem_req_s = 1'b0;
                        m_done_s  = 1'b1;
                        m_err_s   = err_r;
                    end else begin
                        beat_s     = beat_r + BW'(1);
                        mem_req_s  = 1'b1;
                        mem_addr_s = base_r + ((32'(beat_r) + 32'd1) << 2);
                    end
                end else begin
                    wait_s = wait_r + WW'(1);
                    if (wait_r == WAIT_LAST) begin
                        err_s     = 1'b1;
                        mem_req_s = 1'b0;
                        m_done_s  = 1'b1;
                        m_err_s   = 1'b1;
                    end else begin
                        mem_req_s = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                mem_req_s = 1'b0;
            end
            default: begin
                mem_req_s = 1'b0;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // Datapath and output registers; only the acked lane is written
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_r     <= {BW{1'b0}};
            wait_r     <= {WW{1'b0}};
            err_r      <= 1'b0;
            base_r     <= 32'd0;
            mem_req_r  <= 1'b0;
            mem_addr_r <= 32'd0;
            m_done_r   <= 1'b0;
            m_err_r    <= 1'b0;
            busy_r     <= 1'b0;
            m_data_r   <= {LW{1'b0}};
        end else begin
            beat_r     <= beat_s;
            wait_r     <= wait_s;
            err_r      <= err_s;
            base_r     <= base_s;
            mem_req_r  <= mem_req_s;
            mem_addr_r <= mem_addr_s;
            m_done_r   <= m_done_s;
            m_err_r    <= m_err_s;
            busy_r     <= busy_s;
            if (lane_we_s) begin
                m_data_r[32*int'(beat_r) +: 32] <= mem_rdata;
            end else begin
                m_data_r <= m_data_r;
            end
        end
    end

    assign m_data   = m_data_r;
    assign m_done   = m_done_r;
    assign m_err    = m_err_r;
    assign busy     = busy_r;
    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;

endmodule

// File: tb/tb_ro_line_fill.sv
// Directed bench for ro_line_fill: table-driven fills plus hand-written
// sequences for ignored inputs, reset mid-fill and back-to-back wrap.
module tb_ro_line_fill;

    localparam int LW    = 512;
    localparam int BEATS = 16;
    localparam int LIMIT = 1000;

    logic          clk;
    logic          rst;
    logic          m_start;
    logic [31:0]   m_addr;
    logic [LW-1:0] m_data;
    logic          m_done;
    logic          m_err;
    logic          busy;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_rdata;
    logic          mem_ack;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_line [BEATS];

    typedef struct {
        logic [31:0] addr;
        int          period;
        logic [31:0] key;
        logic [31:0] base;
        int          acks;
        int          lat;
        logic        err;
    } fill_t;

    fill_t vec [4];

    ro_line_fill #(.LW(LW), .TMO(255)) dut (
        .clk       (clk),
        .rst       (rst),
        .m_start   (m_start),
        .m_addr    (m_addr),
        .m_data    (m_data),
        .m_done    (m_done),
        .m_err     (m_err),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    task automatic chk_line(input string tag);
        for (int i = 0; i < BEATS; i++) begin
            chk(tag, $sformatf("lane%0d", i), m_data[32*i +: 32], exp_line[i]);
        end
    endtask

    // Runs one fill from the current cycle; poke >= 0 pulses m_start while that beat is requested
    task automatic do_fill(input fill_t v, input int poke, input string tag);
        int cyc;
        int beat;
        int rq;
        int bad;
        bit seen;
        logic [31:0] ea;
        beat = 0; rq = 0; bad = 0; seen = 1'b0;
        m_start = 1'b1;
        m_addr  = v.addr;
        step();
        for (cyc = 1; cyc <= LIMIT; cyc++) begin
            mem_ack = 1'b0;
            m_start = 1'b0;
            if (m_done) begin
                seen = 1'b1;
                break;
            end
            if (mem_req && busy) begin
                ea = v.base + 32'(4 * beat);
                if (mem_addr !== ea) bad++;
                if (beat == poke) begin
                    m_start = 1'b1;
                    m_addr  = 32'h99999900;
                end
                if (beat < v.acks && (rq % v.period) == v.period - 1) begin
                    mem_ack        = 1'b1;
                    mem_rdata      = ea ^ v.key;
                    exp_line[beat] = ea ^ v.key;
                    beat++;
                end
                rq++;
            end else begin
                bad++;
            end
            step();
        end
        chk(tag, "done_seen", 32'(seen), 32'd1);
        chk(tag, "latency", 32'(cyc), 32'(v.lat));
        chk(tag, "req_addr_bad", 32'(bad), 32'd0);
        chk(tag, "beats", 32'(beat), 32'(v.acks));
        chk(tag, "m_err", 32'(m_err), 32'(v.err));
        chk(tag, "req_at_done", 32'(mem_req), 32'd0);
        chk(tag, "busy_at_done", 32'(busy), 32'd1);
        chk_line(tag);
        step();
        chk(tag, "done_pulse", 32'(m_done), 32'd0);
        chk(tag, "err_pulse", 32'(m_err), 32'd0);
        chk(tag, "idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int nb;
        vec[0] = '{32'hABCDEF88, 1, 32'h00000000, 32'hABCDEF80, 16, 17, 1'b0};
        vec[1] = '{32'h12345678, 3, 32'hDEADBEEF, 32'h12345640, 16, 49, 1'b0};
        vec[2] = '{32'h0000003F, 2, 32'h5A5A5A5A, 32'h00000000, 16, 33, 1'b0};
        vec[3] = '{32'h40000000, 1, 32'h11111111, 32'h40000000, 5, 261, 1'b1};
        for (int i = 0; i < BEATS; i++) exp_line[i] = 32'd0;

        // Reset with m_start and a stray ack held high
        rst = 1'b1; m_start = 1'b1; m_addr = 32'hFFFFFFFF;
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        step();
        step();
        chk("reset", "mem_req", 32'(mem_req), 32'd0);
        chk("reset", "busy", 32'(busy), 32'd0);
        chk("reset", "m_done", 32'(m_done), 32'd0);
        chk("reset", "m_err", 32'(m_err), 32'd0);
        chk("reset", "mem_addr", mem_addr, 32'd0);
        chk("reset", "m_data_nz", 32'(m_data != '0), 32'd0);
        rst = 1'b0; m_start = 1'b0; mem_ack = 1'b0;
        step();
        chk("reset", "busy_after", 32'(busy), 32'd0);
        chk("reset", "req_after", 32'(mem_req), 32'd0);

        for (int i = 0; i < 4; i++) begin
            do_fill(vec[i], -1, $sformatf("vec%0d", i));
        end

        // m_start during beat 7, then a stray ack while idle
        do_fill('{32'h0BADF00C, 1, 32'h0F0F0F0F, 32'h0BADF000, 16, 17, 1'b0}, 7, "ignore");
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stray", "busy", 32'(busy), 32'd0);
            chk("stray", "mem_req", 32'(mem_req), 32'd0);
            chk("stray", "m_done", 32'(m_done), 32'd0);
        end
        mem_ack = 1'b0;
        chk_line("stray");

        // Reset asserted while beat 9 is being requested
        m_start = 1'b1; m_addr = 32'h20000000;
        step();
        m_start = 1'b0;
        nb = 0;
        for (int c = 0; c < 20 && nb < 9; c++) begin
            mem_ack = 1'b0;
            if (mem_req) begin
                mem_ack = 1'b1;
                mem_rdata = 32'hC0DE0000 + 32'(nb);
                nb++;
            end
            step();
        end
        mem_ack = 1'b0;
        chk("rstmid", "beat9_addr", mem_addr, 32'h20000024);
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h77777777;
        step();
        chk("rstmid", "mem_req", 32'(mem_req), 32'd0);
        chk("rstmid", "busy", 32'(busy), 32'd0);
        chk("rstmid", "m_done", 32'(m_done), 32'd0);
        chk("rstmid", "m_data_nz", 32'(m_data != '0), 32'd0);
        rst = 1'b0;
        step();
        mem_ack = 1'b0;
        chk("rstmid", "m_data_nz_after", 32'(m_data != '0), 32'd0);
        chk("rstmid", "busy_after", 32'(busy), 32'd0);
        chk("rstmid", "m_done_after", 32'(m_done), 32'd0);
        for (int i = 0; i < BEATS; i++) exp_line[i] = 32'd0;

        // Fresh fill at zero, then a back-to-back fill of the top line
        do_fill('{32'h00000000, 1, 32'h00000000, 32'h00000000, 16, 17, 1'b0}, -1, "fresh");
        do_fill('{32'hFFFFFFC4, 1, 32'h00000000, 32'hFFFFFFC0, 16, 17, 1'b0}, -1, "wrap");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
